pipeline_scoreboard: RTL and testbench

- Parametrised register scoreboard for the RV32IMF pipeline. Replaces fixed-depth E/M/W rd comparison with a variable-latency writeback tracker.
- Decode presents each instruction's sources, destination and its result latency (ALU 1, MUL/DIV/FPU longer). The block stalls issue on RAW, WAW or writeback-port conflict.
- Tracks in-flight writes in a writeback-slot shift register and kills young in-flight writes on branch/jump flush.
- Sits between decode and the execute-stage issue point; the single register-file write port is arbitrated by its slot schedule.

---
 rtl/pipeline_scoreboard.sv | 107 ++++++++++
 tb/tb_pipeline_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: variable-latency register scoreboard for the issue stage.
// Schedules the single RF write port via a shifting writeback-slot array and kills young writes on flush.
module pipeline_scoreboard #(
    parameter int NREGS = 32,
    parameter int MAX_LAT = 8,
    parameter int FLUSH_AGE = 2,
    parameter bit BYPASS_WB = 1,
    localparam int AW = $clog2(NREGS),
    localparam int LW = $clog2(MAX_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs1,
    input  logic [AW-1:0] issue_rs2,
    input  logic          issue_rs1_used,
    input  logic          issue_rs2_used,
    input  logic [AW-1:0] issue_rd,
    input  logic          issue_we,
    input  logic [LW-1:0] issue_lat,
    input  logic          flush,
    output logic          stall,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [LW-1:0] inflight,
    output logic          empty
);
    localparam int AGW = FLUSH_AGE > 0 ? $clog2(FLUSH_AGE + 1) : 1;
    localparam logic [LW-1:0] ML = LW'(MAX_LAT);
    localparam logic [AGW-1:0] FA = AGW'(FLUSH_AGE);

    logic [MAX_LAT:1] sv, upv, upl, kill;
    logic [AW-1:0] srd [1:MAX_LAT];
    logic [AW-1:0] uprd [1:MAX_LAT];
    logic [AGW-1:0] sage [1:MAX_LAT];
    logic [AGW-1:0] upage [1:MAX_LAT];
    logic [NREGS-1:0] pend, set, clr;
    logic [LW-1:0] lc;
    logic track, raw1, raw2, waw, conflict, accept;

    // up* is what each slot would receive from the slot above it on the next shift
    genvar g;
    generate
        for (g = 1; g <= MAX_LAT; g++) begin : g_up
            if (g < MAX_LAT) begin : g_mid
                assign upv[g] = sv[g+1];
                assign upl[g] = sv[g+1] & ~kill[g+1];
                assign uprd[g] = srd[g+1];
                assign upage[g] = sage[g+1] == FA ? FA : sage[g+1] + 1'b1;
            end else begin : g_top
                assign upv[g] = 1'b0;
                assign upl[g] = 1'b0;
                assign uprd[g] = '0;
                assign upage[g] = '0;
            end
            assign kill[g] = flush & sv[g] & (sage[g] < FA);
        end
    endgenerate

    assign lc = issue_lat == '0 ? LW'(1) : (issue_lat > ML ? ML : issue_lat);
    assign track = issue_we & (issue_rd != '0);
    assign wb_valid = sv[1] & ~kill[1];
    assign wb_rd = wb_valid ? srd[1] : '0;
    assign raw1 = issue_rs1_used & (issue_rs1 != '0) & pend[issue_rs1]
                & ~(BYPASS_WB & wb_valid & (wb_rd == issue_rs1));
    assign raw2 = issue_rs2_used & (issue_rs2 != '0) & pend[issue_rs2]
                & ~(BYPASS_WB & wb_valid & (wb_rd == issue_rs2));
    assign waw = track & pend[issue_rd];
    // the slot above L shifts onto L at the edge, so it would collide with the new write
    assign conflict = track & upv[lc];
    assign stall = issue_valid & (raw1 | raw2 | waw | conflict);
    assign accept = issue_valid & ~stall & ~flush;
    assign inflight = LW'($countones(sv));
    assign empty = ~|sv;

    always_comb begin
        set = '0;
        clr = '0;
        if (accept && track) set[issue_rd] = 1'b1;
        for (int k = 1; k <= MAX_LAT; k++)
            if (sv[k] && (kill[k] || k == 1)) clr[srd[k]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sv <= '0;
            pend <= '0;
            for (int k = 1; k <= MAX_LAT; k++) begin
                srd[k] <= '0;
                sage[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                if (accept && track && lc == LW'(k)) begin
                    sv[k] <= 1'b1;
                    srd[k] <= issue_rd;
                    sage[k] <= '0;
                end else begin
                    sv[k] <= upl[k];
                    srd[k] <= uprd[k];
                    sage[k] <= upage[k];
                end
            end
            pend <= (pend & ~clr) | set;
        end
    end
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb_pipeline_scoreboard: directed checks of the scoreboard with and without writeback bypass.
module tb_pipeline_scoreboard;
    logic clk = 1'b0;
    logic rst;
    logic issue_valid, issue_rs1_used, issue_rs2_used, issue_we, flush;
    logic [4:0] issue_rs1, issue_rs2, issue_rd;
    logic [3:0] issue_lat;
    logic stall_b, wbv_b, emp_b, stall_n, wbv_n, emp_n;
    logic [4:0] wbrd_b, wbrd_n;
    logic [3:0] inf_b, inf_n;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_scoreboard #(.BYPASS_WB(1)) u_byp (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_we(issue_we), .issue_lat(issue_lat), .flush(flush),
        .stall(stall_b), .wb_valid(wbv_b), .wb_rd(wbrd_b), .inflight(inf_b), .empty(emp_b)
    );

    pipeline_scoreboard #(.BYPASS_WB(0)) u_nob (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_we(issue_we), .issue_lat(issue_lat), .flush(flush),
        .stall(stall_n), .wb_valid(wbv_n), .wb_rd(wbrd_n), .inflight(inf_n), .empty(emp_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rs1 = '0;
        issue_rs2 = '0;
        issue_rs1_used = 1'b0;
        issue_rs2_used = 1'b0;
        issue_rd = '0;
        issue_we = 1'b0;
        issue_lat = '0;
        flush = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [4:0] rd, input logic [3:0] lat);
        issue_valid = 1'b1;
        issue_we = 1'b1;
        issue_rd = rd;
        issue_lat = lat;
    endtask

    task automatic rdop(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        issue_valid = 1'b1;
        issue_rs1 = r1;
        issue_rs2 = r2;
        issue_rs1_used = u1;
        issue_rs2_used = u2;
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b0;
        wr(5, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall_b, 0);
        chk("rst_stall_nob", stall_n, 0);
        chk("rst_empty", emp_b, 1);
        chk("rst_inflight", inf_b, 0);
        chk("rst_wbv", wbv_b, 0);
        chk("rst_wbrd", wbrd_b, 0);
        idle();
        rst = 1'b1;
        repeat (3) begin
            nxt(); #3;
            chk("post_rst_wbv", wbv_b, 0);
            chk("post_rst_empty", emp_b, 1);
        end
        // ALU latency 1 with immediate dependent
        nxt(); wr(3, 1); #3;
        chk("t2_issue_stall", stall_b, 0);
        nxt(); rdop(3, 0, 1, 0); #3;
        chk("t2_wbv", wbv_b, 1);
        chk("t2_wbrd", wbrd_b, 3);
        chk("t2_byp_stall", stall_b, 0);
        chk("t2_nob_stall", stall_n, 1);
        chk("t2_nob_wbv", wbv_n, 1);
        nxt(); rdop(3, 0, 1, 0); #3;
        chk("t2_nob_stall_c2", stall_n, 0);
        chk("t2_wbv_c2", wbv_b, 0);
        // MUL latency 4 feeding rs2
        nxt(); wr(7, 4); #3;
        chk("t3_issue_stall", stall_b, 0);
        for (int i = 1; i <= 3; i++) begin
            nxt(); rdop(0, 7, 0, 1); #3;
            chk("t3_raw_stall", stall_b, 1);
            chk("t3_inflight", inf_b, 1);
        end
        nxt(); rdop(0, 7, 0, 1); #3;
        chk("t3_byp_stall_c4", stall_b, 0);
        chk("t3_wbv_c4", wbv_b, 1);
        chk("t3_wbrd_c4", wbrd_b, 7);
        chk("t3_nob_stall_c4", stall_n, 1);
        nxt(); rdop(0, 7, 0, 1); #3;
        chk("t3_nob_stall_c5", stall_n, 0);
        chk("t3_empty_c5", emp_b, 1);
        // writeback port conflict
        nxt(); wr(8, 3); #3;
        nxt(); wr(9, 2); #3;
        chk("t4_struct_stall", stall_b, 1);
        nxt(); wr(9, 2); #3;
        chk("t4_accept", stall_b, 0);
        nxt(); #3;
        chk("t4_wbv_c3", wbv_b, 1);
        chk("t4_wbrd_c3", wbrd_b, 8);
        chk("t4_inflight_c3", inf_b, 2);
        nxt(); #3;
        chk("t4_wbv_c4", wbv_b, 1);
        chk("t4_wbrd_c4", wbrd_b, 9);
        nxt(); #3;
        chk("t4_empty_c5", emp_b, 1);
        // flush kills both young writes
        nxt(); wr(10, 5); #3;
        nxt(); wr(11, 5); #3;
        chk("t5_issue2_stall", stall_b, 0);
        nxt(); rdop(10, 0, 1, 0); flush = 1'b1; #3;
        chk("t5_flush_stall", stall_b, 1);
        chk("t5_flush_inflight", inf_b, 2);
        nxt(); rdop(10, 0, 1, 0); #3;
        chk("t5_rs10_stall", stall_b, 0);
        chk("t5_empty", emp_b, 1);
        nxt(); rdop(11, 0, 1, 0); #3;
        chk("t5_rs11_stall", stall_b, 0);
        chk("t5_wbv_c4", wbv_b, 0);
        repeat (4) begin
            nxt(); #3;
            chk("t5_no_wbv", wbv_b, 0);
        end
        // old write survives flush; WAW holds
        nxt(); wr(12, 6); #3;
        chk("t6_issue_stall", stall_b, 0);
        for (int i = 1; i <= 6; i++) begin
            nxt(); wr(12, 1); flush = (i == 4); #3;
            chk("t6_waw_stall", stall_b, 1);
            chk("t6_wbv", wbv_b, i == 6);
        end
        chk("t6_wbrd_c6", wbrd_b, 12);
        nxt(); wr(12, 1); #3;
        chk("t6_waw_release", stall_b, 0);
        nxt(); #3;
        chk("t6_wbv_c8", wbv_b, 1);
        chk("t6_wbrd_c8", wbrd_b, 12);
        // young slot 1 killed by flush suppresses its writeback
        nxt(); wr(13, 1); #3;
        nxt(); flush = 1'b1; #3;
        chk("t7_flush_wbv", wbv_b, 0);
        chk("t7_flush_wbrd", wbrd_b, 0);
        chk("t7_inflight", inf_b, 1);
        nxt(); #3;
        chk("t7_empty", emp_b, 1);
        nxt(); wr(13, 1); #3;
        chk("t7_pend_clear", stall_b, 0);
        nxt(); #3;
        chk("t7_wbrd", wbrd_b, 13);
        // latency clamping
        nxt(); wr(14, 0); #3;
        nxt(); #3;
        chk("t8_lat0_wbv", wbv_b, 1);
        chk("t8_lat0_wbrd", wbrd_b, 14);
        nxt(); wr(15, 15); #3;
        for (int i = 1; i <= 8; i++) begin
            nxt(); #3;
            chk("t8_latmax_wbv", wbv_b, i == 8);
        end
        chk("t8_latmax_wbrd", wbrd_b, 15);
        // x0 is never tracked
        nxt(); wr(0, 1); #3;
        nxt(); #3;
        chk("t9_x0_wbv", wbv_b, 0);
        chk("t9_x0_empty", emp_b, 1);
        // reset mid-operation discards slots
        nxt(); wr(16, 3); #3;
        nxt(); rst = 1'b0; #3;
        chk("t10_rst_wbv", wbv_b, 0);
        chk("t10_rst_empty", emp_b, 1);
        nxt(); rst = 1'b1; #3;
        repeat (4) begin
            nxt(); #3;
            chk("t10_no_wbv", wbv_b, 0);
        end
        nxt(); rdop(16, 0, 1, 0); #3;
        chk("t10_pend_clear", stall_n, 0);
        nxt(); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
